// File: rtl/weight_buffer_pkg.sv
// Shared types and helpers for the weight buffer controller.
package weight_buffer_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, LOADED, STREAM} state_e;

    // Count width must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/memory_bank.sv
// Single-port-write / single-port-read RAM with a 1-cycle registered read.
module memory_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/weight_buffer_ctrl.sv
// Load-then-stream buffer controller: fills a memory_bank, then replays it on request
// through a 2-entry skid buffer that hides the RAM read latency.
module weight_buffer_ctrl
    import weight_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             load_ready,
    input  logic             start,
    input  logic             clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [CW-1:0]    loaded_count
);

    state_e           state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    rptr_q, rptr_d;
    logic             rd_pend_q, rd_pend_last_q;
    logic [WIDTH-1:0] skid_data_q [2];
    logic [1:0]       skid_last_q;
    logic             head_q;
    logic [1:0]       occ_q;
    logic             tail;
    logic [WIDTH-1:0] rdata;
    logic             load_fire, pop, flush, room, rd_issue, rd_last;
    logic [2:0]       fill;

    assign load_ready   = !rst && (state_q == IDLE || state_q == LOAD);
    assign load_fire    = load_valid && load_ready;
    assign out_valid    = occ_q != 2'd0;
    assign out_data     = out_valid ? skid_data_q[head_q] : '0;
    assign out_last     = out_valid && skid_last_q[head_q];
    assign pop          = out_valid && out_ready;
    assign busy         = state_q == LOAD || state_q == STREAM;
    assign loaded_count = count_q;
    assign flush        = clear && (state_q == LOADED || state_q == STREAM);
    assign tail         = head_q ^ occ_q[0];

    // Issue a read only if its data is certain to find a free slot when it lands.
    assign fill     = {1'b0, occ_q} + {2'b00, rd_pend_q};
    assign room     = fill <= (3'd1 + {2'b00, pop});
    assign rd_issue = !flush && ((state_q == LOADED && start)
                      || (state_q == STREAM && rptr_q < count_q && room));
    assign rd_last  = rptr_q == count_q - CW'(1);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        rptr_d  = rptr_q;
        if (rd_issue) begin
            rptr_d = rptr_q + CW'(1);
        end
        case (state_q)
            IDLE, LOAD: begin
                if (load_fire) begin
                    wptr_d  = wptr_q + AW'(1);
                    state_d = LOAD;
                    if (load_last || wptr_q == AW'(DEPTH - 1)) begin
                        state_d = LOADED;
                        count_d = CW'(wptr_q) + CW'(1);
                    end
                end
            end
            LOADED: begin
                if (start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (pop && out_last) begin
                    state_d = LOADED;
                    rptr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            wptr_d  = '0;
            count_d = '0;
            rptr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wptr_q         <= '0;
            count_q        <= '0;
            rptr_q         <= '0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            occ_q          <= 2'd0;
            head_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wptr_q         <= wptr_d;
            count_q        <= count_d;
            rptr_q         <= rptr_d;
            rd_pend_q      <= rd_issue;
            rd_pend_last_q <= rd_last;
            if (flush) begin
                occ_q  <= 2'd0;
                head_q <= 1'b0;
            end else begin
                occ_q <= occ_q + {1'b0, rd_pend_q} - {1'b0, pop};
                if (pop) begin
                    head_q <= ~head_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pend_q) begin
            skid_data_q[tail] <= rdata;
            skid_last_q[tail] <= rd_pend_last_q;
        end
    end

    memory_bank #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_memory_bank (
        .clk  (clk),
        .we   (load_fire),
        .waddr(wptr_q),
        .wdata(load_data),
        .raddr(rptr_q[AW-1:0]),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Scoreboard bench for weight_buffer_ctrl at DEPTH=8.
module tb_weight_buffer_ctrl;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk, rst;
    logic          load_valid, load_last, load_ready;
    logic [W-1:0]  load_data;
    logic          start, clear;
    logic          out_valid, out_last, out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
    logic [CW-1:0] loaded_count;

    weight_buffer_ctrl #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .start       (start),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .loaded_count(loaded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] mdl_mem [D];
    int           mdl_count;
    logic [W-1:0] exp_data [$];
    logic         exp_last [$];
    logic [W-1:0] got_data [$];
    logic         got_last [$];
    int           first_cyc, last_cyc, stall_bad;
    bit           timed_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mdl_count = 0;
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic load_words(input logic [W-1:0] base, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = base + W'(i);
            load_last  = with_last && (i == n - 1);
            if (mdl_count < D) begin
                mdl_mem[mdl_count] = base + W'(i);
                mdl_count++;
            end
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
    endtask

    // Pushes the model contents as the expected stream, then pulses start.
    task automatic start_stream();
        for (int i = 0; i < mdl_count; i++) begin
            exp_data.push_back(mdl_mem[i]);
            exp_last.push_back(i == mdl_count - 1);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Captures handshaken words; ready follows pat (LSB first) on valid cycles, then 1.
    task automatic run_stream(input bit [6:0] pat, input int plen, input int max_words,
                              input int budget);
        int           cyc, k, nw;
        bit           stalled, done;
        logic [W-1:0] pd;
        logic         pl;
        cyc = 1; k = 0; nw = 0; stalled = 0; done = 0; pd = '0; pl = 1'b0;
        got_data.delete();
        got_last.delete();
        first_cyc = -1; last_cyc = -1; stall_bad = 0; timed_out = 0;
        while (!done) begin
            if (cyc > budget) begin
                timed_out = 1;
                break;
            end
            if (stalled && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl))
                stall_bad++;
            out_ready = (k < plen) ? pat[k] : 1'b1;
            stalled = 0;
            if (out_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                k++;
                if (out_ready) begin
                    got_data.push_back(out_data);
                    got_last.push_back(out_last);
                    nw++;
                    last_cyc = cyc;
                    if (out_last === 1'b1 || nw == max_words) done = 1;
                end else begin
                    stalled = 1;
                    pd = out_data;
                    pl = out_last;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL rst_load_ready: got %b want 0", load_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (loaded_count !== '0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", loaded_count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL idle_load_ready: got %b want 1", load_ready); end
        mdl_count = 0;
    endtask

    task automatic test_basic();
        logic [W-1:0] e; logic el;
        do_reset();
        load_words(32'hA0, 4, 1);
        n_cmp++; if (loaded_count !== 4'd4) begin n_bad++; $display("FAIL basic_count: got %0d want 4", loaded_count); end
        n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL basic_loaded_ready: got %b want 0", load_ready); end
        start_stream();
        run_stream(7'd0, 0, 0, 40);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout: got timeout want completion"); end
        n_cmp++; if (first_cyc != 2) begin n_bad++; $display("FAIL basic_first_valid: got t+%0d want t+2", first_cyc); end
        n_cmp++; if (last_cyc != 5) begin n_bad++; $display("FAIL basic_last_word: got t+%0d want t+5", last_cyc); end
        n_cmp++; if (got_data.size() != exp_data.size()) begin n_bad++; $display("FAIL basic_words: got %0d want %0d", got_data.size(), exp_data.size()); end
        while (exp_data.size() > 0) begin
            e = exp_data.pop_front(); el = exp_last.pop_front();
            n_cmp++;
            if (got_data.size() == 0) begin n_bad++; $display("FAIL basic_data: got nothing want %0h", e); end
            else if (got_data[0] !== e || got_last[0] !== el) begin n_bad++; $display("FAIL basic_data: got %0h/%b want %0h/%b", got_data[0], got_last[0], e, el); end
            if (got_data.size() > 0) begin void'(got_data.pop_front()); void'(got_last.pop_front()); end
        end
        n_cmp++; if (busy !== 1'b0 || load_ready !== 1'b0 || loaded_count !== 4'd4) begin n_bad++; $display("FAIL basic_back_to_loaded: got busy=%b ready=%b count=%0d want 0/0/4", busy, load_ready, loaded_count); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e; logic el;
        do_reset();
        load_words(32'hA0, 4, 1);
        start_stream();
        run_stream(7'b1101001, 7, 0, 60);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout: got timeout want completion"); end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); end
        n_cmp++; if (got_data.size() != exp_data.size()) begin n_bad++; $display("FAIL bp_words: got %0d want %0d", got_data.size(), exp_data.size()); end
        while (exp_data.size() > 0) begin
            e = exp_data.pop_front(); el = exp_last.pop_front();
            n_cmp++;
            if (got_data.size() == 0) begin n_bad++; $display("FAIL bp_data: got nothing want %0h", e); end
            else if (got_data[0] !== e || got_last[0] !== el) begin n_bad++; $display("FAIL bp_data: got %0h/%b want %0h/%b", got_data[0], got_last[0], e, el); end
            if (got_data.size() > 0) begin void'(got_data.pop_front()); void'(got_last.pop_front()); end
        end
    endtask

    task automatic test_full();
        logic [W-1:0] e; logic el;
        do_reset();
        load_words(32'hC0, 8, 0);
        n_cmp++; if (loaded_count !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d want 8", loaded_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy: got %b want 0", busy); end
        load_valid = 1'b1;
        load_data  = 32'hDEAD;
        #1;
        n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL full_ninth_ready: got %b want 0", load_ready); end
        tick();
        load_valid = 1'b0;
        load_data  = '0;
        n_cmp++; if (loaded_count !== 4'd8) begin n_bad++; $display("FAIL full_count_after: got %0d want 8", loaded_count); end
        start_stream();
        run_stream(7'd0, 0, 0, 60);
        n_cmp++; if (got_data.size() != exp_data.size()) begin n_bad++; $display("FAIL full_words: got %0d want %0d", got_data.size(), exp_data.size()); end
        while (exp_data.size() > 0) begin
            e = exp_data.pop_front(); el = exp_last.pop_front();
            n_cmp++;
            if (got_data.size() == 0) begin n_bad++; $display("FAIL full_data: got nothing want %0h", e); end
            else if (got_data[0] !== e || got_last[0] !== el) begin n_bad++; $display("FAIL full_data: got %0h/%b want %0h/%b", got_data[0], got_last[0], e, el); end
            if (got_data.size() > 0) begin void'(got_data.pop_front()); void'(got_last.pop_front()); end
        end
    endtask

    task automatic test_replay();
        logic [W-1:0] e; logic el;
        do_reset();
        load_words(32'hD0, 4, 1);
        for (int r = 0; r < 2; r++) begin
            start_stream();
            run_stream(7'd0, 0, 0, 40);
            n_cmp++; if (first_cyc != 2) begin n_bad++; $display("FAIL replay_first_valid: run %0d got t+%0d want t+2", r, first_cyc); end
            n_cmp++; if (got_data.size() != exp_data.size()) begin n_bad++; $display("FAIL replay_words: run %0d got %0d want %0d", r, got_data.size(), exp_data.size()); end
            while (exp_data.size() > 0) begin
                e = exp_data.pop_front(); el = exp_last.pop_front();
                n_cmp++;
                if (got_data.size() == 0) begin n_bad++; $display("FAIL replay_data: run %0d got nothing want %0h", r, e); end
                else if (got_data[0] !== e || got_last[0] !== el) begin n_bad++; $display("FAIL replay_data: run %0d got %0h/%b want %0h/%b", r, got_data[0], got_last[0], e, el); end
                if (got_data.size() > 0) begin void'(got_data.pop_front()); void'(got_last.pop_front()); end
            end
        end
    endtask

    task automatic test_clear();
        logic [W-1:0] e; logic el;
        do_reset();
        load_words(32'hA0, 4, 1);
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        mdl_count = 0;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL clr_start_outputs: got valid=%b busy=%b want 0/0", out_valid, busy); end
        n_cmp++; if (loaded_count !== '0 || load_ready !== 1'b1) begin n_bad++; $display("FAIL clr_start_idle: got count=%0d ready=%b want 0/1", loaded_count, load_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_start_no_stream: got valid=%b want 0", out_valid); end
        load_words(32'hE0, 4, 1);
        start_stream();
        run_stream(7'd0, 0, 2, 40);
        for (int i = 0; i < 2; i++) begin
            e = exp_data.pop_front(); el = exp_last.pop_front();
            n_cmp++;
            if (got_data.size() == 0) begin n_bad++; $display("FAIL clr_partial_data: got nothing want %0h", e); end
            else if (got_data[0] !== e || got_last[0] !== el) begin n_bad++; $display("FAIL clr_partial_data: got %0h/%b want %0h/%b", got_data[0], got_last[0], e, el); end
            if (got_data.size() > 0) begin void'(got_data.pop_front()); void'(got_last.pop_front()); end
        end
        exp_data.delete();
        exp_last.delete();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mdl_count = 0;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL clr_stream_outputs: got valid=%b busy=%b want 0/0", out_valid, busy); end
        n_cmp++; if (loaded_count !== '0 || load_ready !== 1'b1) begin n_bad++; $display("FAIL clr_stream_idle: got count=%0d ready=%b want 0/1", loaded_count, load_ready); end
        load_words(32'hF0, 1, 1);
        start_stream();
        run_stream(7'd0, 0, 0, 40);
        n_cmp++; if (got_data.size() != 1 || got_data[0] !== 32'hF0 || got_last[0] !== 1'b1) begin n_bad++; $display("FAIL clr_reload: got %0d words first %0h want 1 word f0", got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0); end
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic test_reset_mid_load();
        logic [W-1:0] e; logic el;
        do_reset();
        load_words(32'h90, 3, 0);
        rst = 1'b1;
        #1;
        n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", load_ready); end
        tick();
        rst = 1'b0;
        mdl_count = 0;
        n_cmp++; if (busy !== 1'b0 || loaded_count !== '0) begin n_bad++; $display("FAIL mid_rst_state: got busy=%b count=%0d want 0/0", busy, loaded_count); end
        load_words(32'hB0, 2, 1);
        start_stream();
        run_stream(7'd0, 0, 0, 40);
        n_cmp++; if (got_data.size() != exp_data.size()) begin n_bad++; $display("FAIL mid_rst_words: got %0d want %0d", got_data.size(), exp_data.size()); end
        while (exp_data.size() > 0) begin
            e = exp_data.pop_front(); el = exp_last.pop_front();
            n_cmp++;
            if (got_data.size() == 0) begin n_bad++; $display("FAIL mid_rst_data: got nothing want %0h", e); end
            else if (got_data[0] !== e || got_last[0] !== el) begin n_bad++; $display("FAIL mid_rst_data: got %0h/%b want %0h/%b", got_data[0], got_last[0], e, el); end
            if (got_data.size() > 0) begin void'(got_data.pop_front()); void'(got_last.pop_front()); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b0;
        mdl_count  = 0;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_full();
        test_replay();
        test_clear();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want summary before time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/weight_buffer_ctrl.md
# weight_buffer_ctrl

Load-then-stream controller for one on-chip weight/activation buffer in the quantized-inference datapath. It accepts a burst of words over a valid/ready load port and writes them to consecutive addresses from 0. It then replays the stored words, on request and any number of times, as a valid/ready stream with backpressure. It owns a `memory_bank` instance (1-cycle registered read) and hides its read latency from the consumer.

## Interface
- `WIDTH`, 32: data word width.
- `DEPTH`, 256: buffer capacity in words; power of two, ≥ 4.
- `AW`, `$clog2(DEPTH)`: address width (derived, not overridden).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `load_valid` in 1: load word present.
- `load_data` in WIDTH: load word.
- `load_last` in 1: final word of the load burst (qualified by `load_valid`).
- `load_ready` out 1: controller accepts a load word this cycle.
- `start` in 1: single-cycle pulse, begin streaming the stored words.
- `clear` in 1: single-cycle pulse, discard the stored contents and abort any stream.
- `out_valid` out 1: stream word present.
- `out_data` out WIDTH: stream word.
- `out_last` out 1: final word of the stream, qualified by `out_valid`.
- `out_ready` in 1: consumer accepts the stream word.
- `busy` out 1: high in LOAD and STREAM.
- `loaded_count` out AW+1: number of stored words, 0..DEPTH.

## Operation
- States: IDLE, LOAD, LOADED, STREAM. Reset state is IDLE.
- Load handshake: a word transfers when `load_valid && load_ready`. It is written to address `wptr`, and `wptr` increments.
- IDLE: `load_ready`=1. The first transfer goes to LOAD, or to LOADED if `load_last`=1.
- LOAD: `load_ready`=1. A transfer with `load_last`, or a transfer to address DEPTH-1, goes to LOADED.
- On entry to LOADED, `loaded_count` = number of words transferred.
- LOADED: `load_ready`=0. `start` goes to STREAM with the read pointer at 0.
- STREAM: reads addresses 0..`loaded_count`-1 in order. Every word is delivered exactly once; none is lost or duplicated under backpressure. The handshake of word `loaded_count`-1, which carries `out_last`=1, returns the block to LOADED.
- Repeated `start`s replay identical sequences.
- `clear` in LOADED or STREAM goes to IDLE:
  - `loaded_count`=0, `wptr`=0.
  - The output buffer is flushed.
  - RAM contents are not erased.
- `clear` in IDLE or LOAD is ignored. `start` outside LOADED is ignored.
- `start` and `clear` in the same cycle: `clear` wins.
- `rst` mid-operation has the same effect as `clear`, from any state.
- Reset values of outputs:
  - `load_ready`=0 while `rst`=1.
  - `out_valid`=0, `out_last`=0, `out_data`=0.
  - `busy`=0, `loaded_count`=0.
- `load_ready` is combinational from state and is forced 0 while `rst` is high.

## Timing
- Load throughput is 1 word/cycle.
- `loaded_count` updates in the cycle after the final load transfer.
- `start` sampled in cycle t: first `out_valid` in cycle t+2.
- With `out_ready` held high, words follow every cycle with no bubbles.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_last` are held stable.
- Latency is covered by a 2-entry skid/output buffer. A RAM read is issued only when a buffer slot is guaranteed free for its data.
- Back-to-back stream: `start` is accepted in the cycle after the `out_last` handshake, at the earliest.
- `clear` in cycle t: `out_valid`=0 and `busy`=0 from t+1.

## Structure
- Package `weight_buffer_pkg` holds:
  - the state typedef: enum `logic [1:0]` {IDLE, LOAD, LOADED, STREAM};
  - a helper function computing count width from DEPTH.
- One sub-module: `memory_bank` (WIDTH, DEPTH), driven with `we`, `waddr`, `wdata`, `raddr`. No other sub-modules. The skid buffer stays inline.

## Test plan
- Basic load/stream:
  - Stimulus: DEPTH=8; load 0xA0..0xA3 with `load_last` on 0xA3; `start` at t; `out_ready`=1.
  - Required: `loaded_count`=4; 0xA0..0xA3 on cycles t+2..t+5; `out_last` only on 0xA3; block returns to LOADED.
- Backpressure:
  - Stimulus: same load; `out_ready` pattern 1,0,0,1,0,1,1.
  - Required: exactly 0xA0..0xA3 in order; data stable while stalled; no duplicates.
- Full buffer:
  - Stimulus: DEPTH=8; 8 words, no `load_last`.
  - Required: LOADED after the 8th word; `load_ready`=0; a 9th `load_valid` is not accepted; `loaded_count`=8.
- Replay:
  - Stimulus: two `start`s after completion.
  - Required: two identical 4-word sequences.
- Clear precedence:
  - Stimulus: `start`+`clear` in the same cycle in LOADED; separately, `clear` after 2 stream words.
  - Required: both go to IDLE; `out_valid`=0 next cycle; `loaded_count`=0.
- Reset mid-load:
  - Stimulus: `rst` after 3 words, then load 0xB0..0xB1 and stream.
  - Required: `load_ready`=0 during `rst`; stream yields 0xB0, 0xB1 only.
